writeback_buffer: RTL

Write-side front end for the 32×64-bit RISC-V register file. It accepts writeback results from two sources, the ALU and the load/memory path, and queues them in a small in-order FIFO. It drains one entry per cycle into the register file's write port (regWrite / writeRegister / writeData). It also provides two forwarding lookups, so that reads of registers with pending writes return the newest value.

---
 rtl/writeback_buffer.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/writeback_buffer.sv
// writeback_buffer: merges ALU and load writeback results into a small in-order
// FIFO. The FIFO drains one entry per cycle into the register-file write port
// and provides two newest-first forwarding lookups over everything still pending.
module writeback_buffer #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 64,
  parameter int ADDR  = 5
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         aluValid,
  input  logic [ADDR-1:0]              aluRd,
  input  logic [XLEN-1:0]              aluData,
  output logic                         aluReady,
  input  logic                         memValid,
  input  logic [ADDR-1:0]              memRd,
  input  logic [XLEN-1:0]              memData,
  output logic                         memReady,
  output logic                         regWrite,
  output logic [ADDR-1:0]              writeRegister,
  output logic [XLEN-1:0]              writeData,
  input  logic [ADDR-1:0]              lookupRegister1,
  input  logic [ADDR-1:0]              lookupRegister2,
  output logic                         hit1,
  output logic                         hit2,
  output logic [XLEN-1:0]              fwdData1,
  output logic [XLEN-1:0]              fwdData2,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTRW = $clog2(DEPTH);
  localparam int CNTW = $clog2(DEPTH+1);

  // Entry storage. It is read in parallel by the forwarding search, so it
  // cannot be a single-port RAM.
  logic [ADDR-1:0] rdMem   [DEPTH];
  logic [XLEN-1:0] dataMem [DEPTH];

  logic [PTRW-1:0] headReg, tailReg;
  logic [PTRW-1:0] headNext, tailNext, aluSlot;
  logic [CNTW-1:0] countReg, countNext, freeSlots;
  logic            regWriteReg;
  logic [ADDR-1:0] writeRegisterReg;
  logic [XLEN-1:0] writeDataReg;

  logic memPush, aluPush, pop;

  // Readiness uses only the registered count. A same-cycle pop is not
  // credited, which keeps the ready paths short.
  assign freeSlots = CNTW'(DEPTH) - countReg;
  assign memReady  = reset && (freeSlots != '0);
  assign aluReady  = reset && (memValid ? (freeSlots >= CNTW'(2)) : (freeSlots != '0));

  // Writes to x0 complete the handshake, but they never occupy a slot.
  assign memPush = memValid && memReady && (memRd != '0);
  assign aluPush = aluValid && aluReady && (aluRd != '0);
  assign pop     = (countReg != '0);

  // The mem entry is older, so it takes the tail slot. The ALU entry follows it.
  assign aluSlot   = tailReg + PTRW'(memPush);
  assign tailNext  = tailReg + PTRW'(memPush) + PTRW'(aluPush);
  assign headNext  = headReg + PTRW'(pop);
  assign countNext = countReg + CNTW'(memPush) + CNTW'(aluPush) - CNTW'(pop);

  // Entry write port. Pushes are already blocked while reset is low.
  always_ff @(posedge clock) begin
    if (memPush) begin
      rdMem[tailReg]   <= memRd;
      dataMem[tailReg] <= memData;
    end
    if (aluPush) begin
      rdMem[aluSlot]   <= aluRd;
      dataMem[aluSlot] <= aluData;
    end
  end

  // Pointer, count and output-stage registers.
  // The output stage holds its index and data whenever the FIFO is empty.
  always_ff @(posedge clock) begin
    if (!reset) begin
      headReg          <= '0;
      tailReg          <= '0;
      countReg         <= '0;
      regWriteReg      <= 1'b0;
      writeRegisterReg <= '0;
      writeDataReg     <= '0;
    end else begin
      headReg     <= headNext;
      tailReg     <= tailNext;
      countReg    <= countNext;
      regWriteReg <= pop;
      if (pop) begin
        writeRegisterReg <= rdMem[headReg];
        writeDataReg     <= dataMem[headReg];
      end
    end
  end

  assign regWrite      = regWriteReg;
  assign writeRegister = writeRegisterReg;
  assign writeData     = writeDataReg;
  assign count         = countReg;

  // Forwarding: one identical search per lookup port.
  logic [2*ADDR-1:0] lookupFlat;
  logic [1:0]        hitFlat;
  logic [2*XLEN-1:0] fwdFlat;

  assign lookupFlat = {lookupRegister2, lookupRegister1};

  for (genvar gi = 0; gi < 2; gi++) begin : gLookup
    logic [ADDR-1:0] query;
    logic [PTRW-1:0] slot;
    logic            hitLocal;
    logic [XLEN-1:0] fwdLocal;

    assign query = lookupFlat[gi*ADDR +: ADDR];

    // Scan from the oldest match to the newest match, so that the newest match
    // wins. The output stage is seeded first because it has the lowest priority.
    always_comb begin
      hitLocal = 1'b0;
      fwdLocal = '0;
      slot     = headReg;
      if (regWriteReg && (writeRegisterReg == query)) begin
        hitLocal = 1'b1;
        fwdLocal = writeDataReg;
      end
      for (int k = 0; k < DEPTH; k++) begin
        slot = headReg + PTRW'(k);
        if ((CNTW'(k) < countReg) && (rdMem[slot] == query)) begin
          hitLocal = 1'b1;
          fwdLocal = dataMem[slot];
        end
      end
      if (query == '0) begin
        hitLocal = 1'b0;
        fwdLocal = '0;
      end
    end

    assign hitFlat[gi]               = hitLocal;
    assign fwdFlat[gi*XLEN +: XLEN]  = fwdLocal;
  end

  assign hit1     = hitFlat[0];
  assign hit2     = hitFlat[1];
  assign fwdData1 = fwdFlat[0 +: XLEN];
  assign fwdData2 = fwdFlat[XLEN +: XLEN];

endmodule
